// File: rtl/mem_loader_pkg.sv
// Shared constants and FSM encoding for the serial frame-to-memory loader.
// S_CSUM only exists when MEM_LOADER_CHECKSUM_EN is defined.
package mem_loader_pkg;

  localparam int DEF_ADDRESS_WIDTH = 17;
  localparam int DEF_DATA_WIDTH    = 16;
  // ADDR2, ADDR1, ADDR0, LENH, LENL
  localparam int HDR_BYTES         = 5;

`ifdef MEM_LOADER_CHECKSUM_EN
  typedef enum logic [3:0] {
    S_ADDR2 = 4'd0,
    S_ADDR1 = 4'd1,
    S_ADDR0 = 4'd2,
    S_LENH  = 4'd3,
    S_LENL  = 4'd4,
    S_DHI   = 4'd5,
    S_DLO   = 4'd6,
    S_CSUM  = 4'd7,
    S_DONE  = 4'd8
  } state_e;
`else
  typedef enum logic [3:0] {
    S_ADDR2 = 4'd0,
    S_ADDR1 = 4'd1,
    S_ADDR0 = 4'd2,
    S_LENH  = 4'd3,
    S_LENL  = 4'd4,
    S_DHI   = 4'd5,
    S_DLO   = 4'd6,
    S_DONE  = 4'd8
  } state_e;
`endif

endpackage

// File: rtl/mem_loader.sv
// Parses ADDR2/ADDR1/ADDR0/LENH/LENL + 2*count data byte frames into one-cycle memory writes.
// Optional trailing XOR checksum byte when MEM_LOADER_CHECKSUM_EN is defined.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [7:0]               in_byte,
  output logic                     in_ready,
  output logic                     write_enable,
  output logic [ADDRESS_WIDTH-1:0] write_address,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [3:0]               dbg_state
);

  // Handshake: a byte transfers on a rising edge where in_valid && in_ready;
  // in_ready is high in every byte-collecting state, low in S_DONE and during reset.

`ifdef MEM_LOADER_CHECKSUM_EN
  localparam state_e S_END = S_CSUM;
`else
  localparam state_e S_END = S_DONE;
`endif

  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

  state_e                   state_q, state_d;
  logic                     a16_q, a16_d;
  logic [7:0]               a15_8_q, a15_8_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]              cnt_q, cnt_d;
  logic [7:0]               hi_q, hi_d;
  logic                     we_q, we_d;
  logic [ADDRESS_WIDTH-1:0] wa_q, wa_d;
  logic [DATA_WIDTH-1:0]    dout_q, dout_d;
  logic                     accept;
  logic [15:0]              len_full;
`ifdef MEM_LOADER_CHECKSUM_EN
  logic [7:0]               csum_q, csum_d;
  logic                     err_q, err_d;
`endif

  assign in_ready = ~reset & (state_q != S_DONE);
  assign accept   = in_valid & in_ready;
  assign len_full = {cnt_q[15:8], in_byte};

  always_comb begin
    state_d = state_q;
    a16_d   = a16_q;
    a15_8_d = a15_8_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    we_d    = 1'b0;
    wa_d    = wa_q;
    dout_d  = dout_q;
`ifdef MEM_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      S_ADDR2: if (accept) begin
        a16_d   = in_byte[0];
        state_d = S_ADDR1;
      end
      S_ADDR1: if (accept) begin
        a15_8_d = in_byte;
        state_d = S_ADDR0;
      end
      S_ADDR0: if (accept) begin
        addr_d  = ADDRESS_WIDTH'({a16_q, a15_8_q, in_byte});
        state_d = S_LENH;
      end
      S_LENH: if (accept) begin
        cnt_d   = {in_byte, 8'h00};
        state_d = S_LENL;
      end
      S_LENL: if (accept) begin
        cnt_d   = len_full;
        state_d = (len_full == 16'd0) ? S_END : S_DHI;
      end
      S_DHI: if (accept) begin
        hi_d    = in_byte;
        state_d = S_DLO;
      end
      S_DLO: if (accept) begin
        we_d    = 1'b1;
        wa_d    = addr_q;
        dout_d  = DATA_WIDTH'({hi_q, in_byte});
        addr_d  = addr_q + ADDR_ONE;
        cnt_d   = cnt_q - 16'd1;
        state_d = (cnt_q == 16'd1) ? S_END : S_DHI;
      end
`ifdef MEM_LOADER_CHECKSUM_EN
      S_CSUM: if (accept) begin
        err_d   = (in_byte != csum_q);
        state_d = S_DONE;
      end
`endif
      S_DONE:  state_d = S_ADDR2;
      default: state_d = S_ADDR2;
    endcase
`ifdef MEM_LOADER_CHECKSUM_EN
    // ADDR2 restarts the running XOR; the checksum byte itself is excluded.
    if (accept && state_q != S_CSUM) begin
      csum_d = (state_q == S_ADDR2) ? in_byte : (csum_q ^ in_byte);
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= S_ADDR2;
      a16_q   <= 1'b0;
      a15_8_q <= 8'h00;
      addr_q  <= '0;
      cnt_q   <= 16'h0000;
      hi_q    <= 8'h00;
      we_q    <= 1'b0;
      wa_q    <= '0;
      dout_q  <= '0;
`ifdef MEM_LOADER_CHECKSUM_EN
      csum_q  <= 8'h00;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a16_q   <= a16_d;
      a15_8_q <= a15_8_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      dout_q  <= dout_d;
`ifdef MEM_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
      err_q   <= err_d;
`endif
    end
  end

  // Gating with reset cancels a write or done that was registered the cycle before.
  assign write_enable  = we_q & ~reset;
  assign write_address = wa_q;
  assign data_out      = dout_q;
  assign busy          = ~reset & (state_q != S_ADDR2) & (state_q != S_DONE);
  assign done          = ~reset & (state_q == S_DONE);
`ifdef MEM_LOADER_CHECKSUM_EN
  assign error         = ~reset & err_q;
`else
  assign error         = 1'b0;
`endif
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: stimulus pushes expected writes/done pulses,
// a negedge monitor pops and compares them.
module tb_mem_loader;
  import mem_loader_pkg::*;

  localparam int AW = 17;
  localparam int DW = 16;

  logic          CLK = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [7:0]    in_byte;
  logic          in_ready;
  logic          write_enable;
  logic [AW-1:0] write_address;
  logic [DW-1:0] data_out;
  logic          busy;
  logic          done;
  logic          error;
  logic [3:0]    dbg_state;

  mem_loader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK(CLK), .reset(reset), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready), .write_enable(write_enable), .write_address(write_address),
    .data_out(data_out), .busy(busy), .done(done), .error(error), .dbg_state(dbg_state)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  bit gaps     = 1'b0;

  logic [AW+DW-1:0] exp_q[$];
  logic             exp_done_q[$];
  logic [7:0]       frame_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // Monitor: every write and every done pulse must match the head of its queue.
  always @(negedge CLK) begin
    logic [AW+DW-1:0] e;
    logic             ee;
    if (write_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        fail_now($sformatf("unexpected_write addr=%0h data=%0h required=none", write_address, data_out));
      end else begin
        e = exp_q.pop_front();
        check("write_address", 64'(write_address), 64'(e[AW+DW-1:DW]));
        check("data_out", 64'(data_out), 64'(e[DW-1:0]));
      end
    end
    if (done === 1'b1) begin
      if (exp_done_q.size() == 0) begin
        fail_now("unexpected_done actual=1 required=0");
      end else begin
        ee = exp_done_q.pop_front();
        check("done_error", 64'(error), 64'(ee));
        check("done_in_ready", 64'(in_ready), 64'd0);
      end
    end else if (error !== 1'b0) begin
      fail_now("stray_error actual=1 required=0");
    end
  end

  task automatic send_byte(input logic [7:0] b);
    logic rdy;
    int   n;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        @(posedge CLK);
        #1;
      end
    end
    in_valid = 1'b1;
    in_byte  = b;
    n = 0;
    forever begin
      @(negedge CLK);
      rdy = in_ready;
      @(posedge CLK);
      #1;
      if (rdy) break;
      n++;
      if (n > 50) begin
        fail_now("in_ready_timeout");
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 || exp_done_q.size() != 0) begin
      @(negedge CLK);
      #1;
      n++;
      if (n > 20) begin
        fail_now("frame_end_timeout");
        exp_q.delete();
        exp_done_q.delete();
      end
    end
  endtask

  // Sends frame_q (plus checksum byte when compiled in) and expects one done pulse.
  task automatic send_frame(input bit bad_csum);
    logic [7:0] x;
    x = 8'h00;
`ifdef MEM_LOADER_CHECKSUM_EN
    exp_done_q.push_back(bad_csum);
`else
    exp_done_q.push_back(1'b0);
`endif
    foreach (frame_q[i]) begin
      x ^= frame_q[i];
      send_byte(frame_q[i]);
      if (i == 0) check("busy_in_frame", 64'(busy), 64'd1);
    end
`ifdef MEM_LOADER_CHECKSUM_EN
    send_byte(bad_csum ? ~x : x);
`endif
    wait_idle();
    check("busy_after_frame", 64'(busy), 64'd0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge CLK);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_write_enable", 64'(write_enable), 64'd0);
    @(posedge CLK);
    #1;
    reset = 1'b0;
    @(negedge CLK);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_write_address", 64'(write_address), 64'd0);
    check("post_rst_data_out", 64'(data_out), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_state", 64'(dbg_state), 64'(S_ADDR2));
    repeat (4) @(posedge CLK);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset_in_ready", 64'(in_ready), 64'd0);
    @(posedge CLK);
    #1;
    reset = 1'b0;
    @(negedge CLK);
    check("init_in_ready", 64'(in_ready), 64'd1);
    check("init_write_enable", 64'(write_enable), 64'd0);
    check("init_write_address", 64'(write_address), 64'd0);
    check("init_data_out", 64'(data_out), 64'd0);
    check("init_busy", 64'(busy), 64'd0);
    check("init_done", 64'(done), 64'd0);
    check("init_error", 64'(error), 64'd0);
    @(posedge CLK);
    #1;

    // Basic two-word frame at 0x0100
    frame_q = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h02, 8'hAB, 8'hCD, 8'h12, 8'h34};
    push_wr(17'h00100, 16'hABCD);
    push_wr(17'h00101, 16'h1234);
    send_frame(1'b0);

    // Address wrap 0x1FFFF -> 0x00000
    frame_q = '{8'h01, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44};
    push_wr(17'h1FFFF, 16'h1122);
    push_wr(17'h00000, 16'h3344);
    send_frame(1'b0);

    // Zero count: no writes, outputs hold last write
    frame_q = '{8'h00, 8'h00, 8'h10, 8'h00, 8'h00};
    send_frame(1'b0);
    check("hold_write_address", 64'(write_address), 64'h00000);
    check("hold_data_out", 64'(data_out), 64'h3344);

    // ADDR2 bits 7:1 ignored
    frame_q = '{8'hFE, 8'h12, 8'h34, 8'h00, 8'h01, 8'h5A, 8'hA5};
    push_wr(17'h01234, 16'h5AA5);
    send_frame(1'b0);

    // Four-word frame with random in_valid gaps
    gaps = 1'b1;
    frame_q = '{8'h00, 8'h0A, 8'hB0, 8'h00, 8'h04,
                8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
    push_wr(17'h00AB0, 16'hDEAD);
    push_wr(17'h00AB1, 16'hBEEF);
    push_wr(17'h00AB2, 16'h0123);
    push_wr(17'h00AB3, 16'h4567);
    send_frame(1'b0);
    gaps = 1'b0;

`ifdef MEM_LOADER_CHECKSUM_EN
    // Flipped checksum: writes still land, error with done
    frame_q = '{8'h00, 8'h02, 8'h00, 8'h00, 8'h01, 8'hC3, 8'h3C};
    push_wr(17'h00200, 16'hC33C);
    send_frame(1'b1);
`endif

    // Reset after the DHI byte: frame abandoned
    for (int i = 0; i < HDR_BYTES; i++) begin
      send_byte((i == 1) ? 8'h03 : ((i == 4) ? 8'h01 : 8'h00));
    end
    send_byte(8'hAB);
    pulse_reset();

    // Reset in the cycle a write is registered: write cancelled
    for (int i = 0; i < HDR_BYTES; i++) begin
      send_byte((i == 1) ? 8'h04 : ((i == 4) ? 8'h01 : 8'h00));
    end
    send_byte(8'h55);
    send_byte(8'h66);
    pulse_reset();

    // Recovery frame after resets
    frame_q = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h02, 8'hAB, 8'hCD, 8'h12, 8'h34};
    push_wr(17'h00100, 16'hABCD);
    push_wr(17'h00101, 16'h1234);
    send_frame(1'b0);

    repeat (3) @(posedge CLK);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 17, write-address width matching the widest memory_block port.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, word width written to memory.
REQ-003 SHALL have port CLK  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  byte available on in_byte.
REQ-006 SHALL have port in_byte  input  8  frame byte from upstream (UART receiver or host).
REQ-007 SHALL have port in_ready  output  1  byte accepted when in_valid && in_ready at a clock edge.
REQ-008 SHALL have port write_enable  output  1  one-cycle write strobe to the memory write port.
REQ-009 SHALL have port write_address  output  ADDRESS_WIDTH  word address for the write.
REQ-010 SHALL have port data_out  output  DATA_WIDTH  word driven to memory data_in.
REQ-011 SHALL have port busy  output  1  high from first accepted byte until frame end.
REQ-012 SHALL have port done  output  1  one-cycle pulse at frame end.
REQ-013 SHALL have port error  output  1  one-cycle pulse, coincident with done, on checksum mismatch.

Function
REQ-014 Frame SHALL be: ADDR2 (bit0 = addr[16], bits 7:1 ignored), ADDR1 (addr[15:8]), ADDR0 (addr[7:0]), LENH, LENL (16-bit word count), then 2*count data bytes, high byte first.
REQ-015 FSM states SHALL be S_ADDR2, S_ADDR1, S_ADDR0, S_LENH, S_LENL, S_DHI, S_DLO, S_CSUM (macro only), S_DONE; each byte state advances only on an accepted byte.
REQ-016 S_LENL with count 0 SHALL go to S_CSUM if compiled in, else S_DONE; no write issued.
REQ-017 Accepting the S_DLO byte SHALL register write_enable=1, write_address=current address, data_out={hi,lo} on the next cycle, for exactly one cycle.
REQ-018 Address SHALL increment by 1 after each write, wrapping from 2^ADDRESS_WIDTH-1 to 0.
REQ-019 Remaining count SHALL decrement per write; after the last write go to S_CSUM or S_DONE.
REQ-020 in_ready SHALL be 1 in every byte state and 0 in S_DONE; S_DONE lasts one cycle, pulses done, then returns to S_ADDR2.
REQ-021 Back-to-back bytes every cycle SHALL be sustained with no byte dropped; in_valid low simply stalls the FSM.
REQ-022 write_enable, done, error SHALL be 0 except in their defined pulse cycles; write_address/data_out hold last value between writes.

Reset
REQ-023 Reset SHALL force S_ADDR2, in_ready=0 during the reset cycle and 1 after, write_enable=0, write_address=0, data_out=0, busy=0, done=0, error=0, checksum=0.
REQ-024 Reset mid-frame SHALL abandon the frame with no further writes and no done pulse; a write already registered that cycle SHALL be cancelled.

Configuration
REQ-025 Macro MEM_LOADER_CHECKSUM_EN defined: S_CSUM expects one byte equal to XOR of all preceding frame bytes; mismatch pulses error with done; writes already made are not undone.
REQ-026 Macro undefined: no S_CSUM state or checksum register; error tied to 0; frame ends after the last data byte.

Structure
REQ-027 Shared package SHALL hold FSM state encoding, frame-field byte count, and default ADDRESS_WIDTH/DATA_WIDTH constants.
REQ-028 Single flat module; no sub-module required.

Verification
REQ-029 Frame 00 01 00 00 02 AB CD 12 34 -> writes 0x0100=0xABCD, 0x0101=0x1234, done once, busy low after.
REQ-030 Frame 01 FF FF 00 02 data -> writes at 0x1FFFF then 0x00000 (wrap).
REQ-031 Count 0000 -> no write_enable, done pulse after LENL (or checksum byte if enabled).
REQ-032 With MEM_LOADER_CHECKSUM_EN, correct XOR byte -> done, error=0; flipped byte -> done and error same cycle.
REQ-033 Reset asserted after S_DHI byte -> no write, no done; next full frame writes correctly.
REQ-034 in_valid toggled randomly across a 4-word frame -> same writes and addresses as contiguous stream.
